// File: rtl/bf_io_buffer.sv
// Host/machine I/O buffer: an input FIFO (host -> machine) and an output FIFO
// (machine -> host), with end-of-input latching and an optional EOF filler word.

module bf_io_fifo #(
  parameter  int WORD_SIZE = 8,
  parameter  int DEPTH     = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module bf_io_buffer #(
  parameter  int WORD_SIZE = 8,
  parameter  int DEPTH     = 4,
  parameter  int EOF_MODE  = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] host_in_data,
  input  logic                 host_in_valid,
  output logic                 host_in_ready,
  input  logic                 host_in_eof,
  output logic [WORD_SIZE-1:0] machine_input,
  output logic                 machine_input_valid,
  input  logic                 machine_input_ready,
  input  logic [WORD_SIZE-1:0] machine_output,
  input  logic                 machine_output_valid,
  output logic                 machine_output_ready,
  output logic [WORD_SIZE-1:0] host_out_data,
  output logic                 host_out_valid,
  input  logic                 host_out_ready,
  output logic [CW-1:0]        in_count,
  output logic [CW-1:0]        out_count,
  output logic                 eof_seen
);

  localparam logic [WORD_SIZE-1:0] EOF_FILL =
    (EOF_MODE == 2) ? {WORD_SIZE{1'b1}} : {WORD_SIZE{1'b0}};

  logic                 run_q, run_d;
  logic                 eof_seen_q, eof_seen_d;
  logic                 in_push, in_pop, in_full, in_empty;
  logic                 out_push, out_pop, out_full, out_empty;
  logic [WORD_SIZE-1:0] in_head, out_head;

  // run_q holds the handshakes off until the first edge after reset is released.
  always_comb begin
    run_d      = 1'b1;
    eof_seen_d = eof_seen_q | host_in_eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      eof_seen_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      eof_seen_q <= eof_seen_d;
    end
  end

  always_comb begin
    host_in_ready        = run_q && !in_full && !eof_seen_q;
    machine_output_ready = run_q && !out_full;
    machine_input_valid  = 1'b0;
    machine_input        = '0;
    host_out_valid       = run_q && !out_empty;
    host_out_data        = host_out_valid ? out_head : '0;
    if (run_q && !in_empty) begin
      machine_input_valid = 1'b1;
      machine_input       = in_head;
    end else if (run_q && eof_seen_q && (EOF_MODE != 0)) begin
      machine_input_valid = 1'b1;
      machine_input       = EOF_FILL;
    end
  end

  // EOF filler words are consumed without touching the input FIFO.
  assign in_push  = host_in_valid && host_in_ready;
  assign in_pop   = machine_input_valid && machine_input_ready && !in_empty;
  assign out_push = machine_output_valid && machine_output_ready;
  assign out_pop  = host_out_valid && host_out_ready;
  assign eof_seen = eof_seen_q;

  bf_io_fifo #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_push),
    .wr_data (host_in_data),
    .pop     (in_pop),
    .rd_data (in_head),
    .count   (in_count),
    .full    (in_full),
    .empty   (in_empty)
  );

  bf_io_fifo #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (out_push),
    .wr_data (machine_output),
    .pop     (out_pop),
    .rd_data (out_head),
    .count   (out_count),
    .full    (out_full),
    .empty   (out_empty)
  );

endmodule

// File: tb/tb_bf_io_buffer.sv
// Self-checking bench for bf_io_buffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the two FIFOs and the EOF rule.

module tb_bf_io_buffer;

  localparam int WORD_SIZE = 8;
  localparam int DEPTH     = 4;
  localparam int EOF_MODE  = 1;
  localparam int CW        = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic [WORD_SIZE-1:0] host_in_data;
  logic                 host_in_valid;
  logic                 host_in_ready;
  logic                 host_in_eof;
  logic [WORD_SIZE-1:0] machine_input;
  logic                 machine_input_valid;
  logic                 machine_input_ready;
  logic [WORD_SIZE-1:0] machine_output;
  logic                 machine_output_valid;
  logic                 machine_output_ready;
  logic [WORD_SIZE-1:0] host_out_data;
  logic                 host_out_valid;
  logic                 host_out_ready;
  logic [CW-1:0]        in_count;
  logic [CW-1:0]        out_count;
  logic                 eof_seen;

  bf_io_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .EOF_MODE(EOF_MODE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .host_in_data         (host_in_data),
    .host_in_valid        (host_in_valid),
    .host_in_ready        (host_in_ready),
    .host_in_eof          (host_in_eof),
    .machine_input        (machine_input),
    .machine_input_valid  (machine_input_valid),
    .machine_input_ready  (machine_input_ready),
    .machine_output       (machine_output),
    .machine_output_valid (machine_output_valid),
    .machine_output_ready (machine_output_ready),
    .host_out_data        (host_out_data),
    .host_out_valid       (host_out_valid),
    .host_out_ready       (host_out_ready),
    .in_count             (in_count),
    .out_count            (out_count),
    .eof_seen             (eof_seen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: plain queues plus the EOF flag and an "out of reset" flag.
  logic [WORD_SIZE-1:0] inQ[$];
  logic [WORD_SIZE-1:0] outQ[$];
  bit mEof = 1'b0;
  bit mRun = 1'b0;

  function automatic logic [WORD_SIZE-1:0] eofFill();
    return (EOF_MODE == 2) ? {WORD_SIZE{1'b1}} : {WORD_SIZE{1'b0}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model state implies.
  task automatic checkAll();
    logic                 expInRdy, expMiValid, expMoRdy, expHoValid;
    logic [WORD_SIZE-1:0] expMi, expHo;
    expInRdy   = mRun && (inQ.size() < DEPTH) && !mEof;
    expMoRdy   = mRun && (outQ.size() < DEPTH);
    expHoValid = mRun && (outQ.size() > 0);
    expHo      = expHoValid ? outQ[0] : '0;
    expMiValid = 1'b0;
    expMi      = '0;
    if (mRun && inQ.size() > 0) begin
      expMiValid = 1'b1;
      expMi      = inQ[0];
    end else if (mRun && mEof && EOF_MODE != 0) begin
      expMiValid = 1'b1;
      expMi      = eofFill();
    end
    checkOutput("host_in_ready", 32'(host_in_ready), 32'(expInRdy));
    checkOutput("machine_input_valid", 32'(machine_input_valid), 32'(expMiValid));
    checkOutput("machine_input", 32'(machine_input), 32'(expMi));
    checkOutput("machine_output_ready", 32'(machine_output_ready), 32'(expMoRdy));
    checkOutput("host_out_valid", 32'(host_out_valid), 32'(expHoValid));
    checkOutput("host_out_data", 32'(host_out_data), 32'(expHo));
    checkOutput("in_count", 32'(in_count), inQ.size());
    checkOutput("out_count", 32'(out_count), outQ.size());
    checkOutput("eof_seen", 32'(eof_seen), 32'(mEof));
  endtask

  // Called just after a falling edge: drive inputs, advance the model by one
  // rising edge, then check at the following falling edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [WORD_SIZE-1:0] id,
                               input logic ieof, input logic mir, input logic mov,
                               input logic [WORD_SIZE-1:0] mo, input logic hor);
    bit inRdy, miValid, inPop, inPush, outPop, outPush;
    rst = r; host_in_valid = iv; host_in_data = id; host_in_eof = ieof;
    machine_input_ready = mir; machine_output_valid = mov; machine_output = mo;
    host_out_ready = hor;
    inRdy   = mRun && (inQ.size() < DEPTH) && !mEof;
    miValid = mRun && (inQ.size() > 0 || (mEof && EOF_MODE != 0));
    inPop   = miValid && mir && (inQ.size() > 0);
    inPush  = iv && inRdy;
    outPop  = mRun && (outQ.size() > 0) && hor;
    outPush = mov && mRun && (outQ.size() < DEPTH);
    if (r) begin
      inQ.delete(); outQ.delete(); mEof = 1'b0; mRun = 1'b0;
    end else begin
      if (inPop) void'(inQ.pop_front());
      if (inPush) inQ.push_back(id);
      if (outPop) void'(outQ.pop_front());
      if (outPush) outQ.push_back(mo);
      if (ieof) mEof = 1'b1;
      mRun = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input logic mir, input logic hor);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, mir, 1'b0, '0, hor);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("reset_in_count", 32'(in_count), 0);
    checkOutput("reset_host_in_ready", 32'(host_in_ready), 0);
    checkOutput("reset_machine_output_ready", 32'(machine_output_ready), 0);
    idle(1'b0, 1'b0);
    checkOutput("release_host_in_ready", 32'(host_in_ready), 1);
    checkOutput("release_machine_output_ready", 32'(machine_output_ready), 1);
  endtask

  logic [WORD_SIZE-1:0] seq3 [3] = '{8'd3, 8'd9, 8'd5};

  initial begin
    rst = 1'b1; host_in_valid = 1'b0; host_in_data = '0; host_in_eof = 1'b0;
    machine_input_ready = 1'b0; machine_output_valid = 1'b0; machine_output = '0;
    host_out_ready = 1'b0;

    doReset();

    // Words queue while the machine stalls, then drain in order.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, seq3[i], 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("order_in_count", 32'(in_count), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("order_machine_input", 32'(machine_input), 32'(seq3[i]));
      idle(1'b1, 1'b0);
    end
    checkOutput("order_drained_valid", 32'(machine_input_valid), 0);

    // Full input FIFO drops ready; one pop restores it.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("full_host_in_ready", 32'(host_in_ready), 0);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("full_in_count", 32'(in_count), DEPTH);
    idle(1'b1, 1'b0);
    checkOutput("after_pop_host_in_ready", 32'(host_in_ready), 1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b0);

    // Output held stable while the host stalls.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_host_out_valid", 32'(host_out_valid), 1);
      checkOutput("stall_host_out_data", 32'(host_out_data), 7);
      idle(1'b0, 1'b0);
    end
    idle(1'b0, 1'b1);
    checkOutput("stall_second_word", 32'(host_out_data), 8);
    idle(1'b0, 1'b1);

    // Simultaneous push and pop on a half-full output FIFO.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
    checkOutput("pushpop_out_count", 32'(out_count), 2);
    checkOutput("pushpop_head", 32'(host_out_data), 32'h22);
    idle(1'b0, 1'b1);
    checkOutput("pushpop_tail", 32'(host_out_data), 32'h33);
    idle(1'b0, 1'b1);

    // Random traffic on both channels, no EOF.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 9) < 7), 8'($urandom), 1'b0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6), 8'($urandom),
                    1'($urandom_range(0, 9) < 5));
    end

    // EOF: pending word first, then zero filler forever, occupancy unchanged.
    doReset();
    applyStimulus(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("eof_latched", 32'(eof_seen), 1);
    checkOutput("eof_first_word", 32'(machine_input), 5);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("eof_fill_valid", 32'(machine_input_valid), 1);
      checkOutput("eof_fill_data", 32'(machine_input), 0);
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("eof_in_count", 32'(in_count), 0);
      checkOutput("eof_host_in_ready", 32'(host_in_ready), 0);
    end

    // Reset mid-stream discards queued words and the latched EOF.
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("midreset_pre_in_count", 32'(in_count), 3);
    checkOutput("midreset_pre_eof", 32'(eof_seen), 1);
    applyStimulus(1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h62, 1'b1);
    checkOutput("midreset_in_count", 32'(in_count), 0);
    checkOutput("midreset_out_count", 32'(out_count), 0);
    checkOutput("midreset_eof", 32'(eof_seen), 0);
    checkOutput("midreset_mi_valid", 32'(machine_input_valid), 0);
    checkOutput("midreset_ho_valid", 32'(host_out_valid), 0);
    idle(1'b0, 1'b0);
    checkOutput("midreset_release_ready", 32'(host_in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bf_io_buffer.md
BF_IO_BUFFER -- requirements
Module: bf_io_buffer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per FIFO; a power of two, at least 2.
REQ-003 SHALL have parameter EOF_MODE, default 0, end-of-input policy: 0 stall, 1 supply zero, 2 supply all-ones.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port host_in_data  input  WORD_SIZE  word from host toward the machine.
REQ-007 SHALL have port host_in_valid  input  1  host_in_data is valid.
REQ-008 SHALL have port host_in_ready  output  1  buffer accepts a host input word.
REQ-009 SHALL have port host_in_eof  input  1  single-cycle pulse: host input stream ended.
REQ-010 SHALL have port machine_input  output  WORD_SIZE  word presented to the machine.
REQ-011 SHALL have port machine_input_valid  output  1  machine_input is valid.
REQ-012 SHALL have port machine_input_ready  input  1  machine consumes machine_input.
REQ-013 SHALL have port machine_output  input  WORD_SIZE  word produced by the machine.
REQ-014 SHALL have port machine_output_valid  input  1  machine_output is valid.
REQ-015 SHALL have port machine_output_ready  output  1  buffer accepts a machine output word.
REQ-016 SHALL have port host_out_data  output  WORD_SIZE  word delivered to the host.
REQ-017 SHALL have port host_out_valid  output  1  host_out_data is valid.
REQ-018 SHALL have port host_out_ready  input  1  host consumes host_out_data.
REQ-019 SHALL have port in_count  output  $clog2(DEPTH+1)  occupancy of the input FIFO.
REQ-020 SHALL have port out_count  output  $clog2(DEPTH+1)  occupancy of the output FIFO.
REQ-021 SHALL have port eof_seen  output  1  EOF has been latched.

Function
REQ-022 SHALL complete a transfer on any channel only on a rising edge where valid and ready are both high.
REQ-023 SHALL implement two independent FIFOs of DEPTH words: input FIFO (host_in to machine_input) and output FIFO (machine_output to host_out), each preserving order.
REQ-024 SHALL register each FIFO's head output, so a word written into an empty FIFO at edge N is presented with valid high from edge N+1 (latency 1, no combinational pass-through).
REQ-025 SHALL drive host_in_ready = !input_full && !eof_seen, and machine_output_ready = !output_full, both from registered state only.
REQ-026 SHALL hold data stable and valid high while valid is high and ready is low.
REQ-027 SHALL, on a simultaneous push and pop on one FIFO, perform both, with the count unchanged.
REQ-028 SHALL never push into a full FIFO and never pop from an empty one; read and write pointers wrap modulo DEPTH.
REQ-029 SHALL latch eof_seen on the first edge where host_in_eof is high; eof_seen stays high until reset.
REQ-030 SHALL, if host_in_eof and a host_in push coincide, accept the word and latch EOF.
REQ-031 SHALL, while eof_seen is high and the input FIFO is empty, drive machine_input_valid low when EOF_MODE=0, and otherwise drive machine_input_valid high with machine_input equal to zero (EOF_MODE=1) or all-ones (EOF_MODE=2).
REQ-032 SHALL not change the input FIFO occupancy when the machine consumes an EOF word.
REQ-033 SHALL deliver words queued before EOF ahead of any EOF word.
REQ-034 SHALL update in_count and out_count on the edge of each push or pop.

Reset
REQ-035 SHALL, on any edge with rst high, clear both FIFOs, set pointers, in_count and out_count to 0, and clear eof_seen.
REQ-036 SHALL, during reset, drive host_in_ready, machine_input_valid, machine_output_ready and host_out_valid to 0, and machine_input and host_out_data to 0.
REQ-037 SHALL, on the first edge after rst falls, raise host_in_ready and machine_output_ready to 1.
REQ-038 SHALL, when reset is asserted mid-transfer, discard all queued data and the latched EOF.

Verification
REQ-039 SHALL be verified: host sends 3, 9, 5 with machine_input_ready held low -> in_count reaches 3; then machine_input_ready held high -> machine receives 3, 9, 5 in order.
REQ-040 SHALL be verified: DEPTH=4, push 4 words with no pops -> host_in_ready low on the edge after the 4th accept; after one pop -> host_in_ready high.
REQ-041 SHALL be verified: machine writes 7, 8 with host_out_ready low for 3 cycles -> host_out_valid high with 7 stable; host then receives 7, 8.
REQ-042 SHALL be verified: EOF_MODE=1, push 5 then pulse host_in_eof -> machine reads 5, then reads 0 repeatedly; host_in_ready stays 0 and in_count stays 0.
REQ-043 SHALL be verified: out_count=2 with a simultaneous push and pop -> out_count stays 2 and order is preserved.
REQ-044 SHALL be verified: rst asserted with in_count=3 and eof_seen=1 -> all counts 0, eof_seen 0, all valids 0 on the next edge.
